// File: rtl/duft_ap_chain_burst_if.sv
// ---------------------------------------------------------------------------
// duft_ap_chain_burst_if
//   Bundles the command/status handshake, the write/read beat data and the
//   core register port of the ap_ctrl_chain burst bridge.
//
//   master : caller + core side (drives command, wr_data, ap_continue,
//            core_rd_msg; observes status, beats and core addresses)
//   slave  : the bridge itself (duft_ap_chain_burst)
//
//   Signals:
//     ap_start, rd_wr, addr, len   command request and fields
//     wr_data / wr_data_ack        write beat data, consumed-pulse
//     rd_beat_data / rd_beat_valid registered read beat, new-beat pulse
//     ap_idle, ap_ready, ap_done   ap_ctrl_chain status
//     ap_continue                  caller acknowledges ap_done
//     ap_return                    burst result
//     err                          sticky IDLE_ADDR-hit flag
//     core_rd_addr, core_wr_addr   core access addresses (IDLE_ADDR if none)
//     core_wr_msg                  core write data (mirrors wr_data)
//     core_rd_msg                  core combinational read data
// ---------------------------------------------------------------------------
interface duft_ap_chain_burst_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              ap_start;
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_ack;
    logic [DATA_W-1:0] rd_beat_data;
    logic              rd_beat_valid;
    logic              ap_idle;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_continue;
    logic [DATA_W-1:0] ap_return;
    logic              err;
    logic [ADDR_W-1:0] core_rd_addr;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_msg;
    logic [DATA_W-1:0] core_rd_msg;

    modport master (
        output ap_start, rd_wr, addr, len, wr_data, ap_continue, core_rd_msg,
        input  wr_data_ack, rd_beat_data, rd_beat_valid, ap_idle, ap_ready,
               ap_done, ap_return, err, core_rd_addr, core_wr_addr, core_wr_msg
    );

    modport slave (
        input  ap_start, rd_wr, addr, len, wr_data, ap_continue, core_rd_msg,
        output wr_data_ack, rd_beat_data, rd_beat_valid, ap_idle, ap_ready,
               ap_done, ap_return, err, core_rd_addr, core_wr_addr, core_wr_msg
    );
endinterface

// File: rtl/duft_ap_chain_burst.sv
// ---------------------------------------------------------------------------
// duft_ap_chain_burst
//   ap_ctrl_chain bridge between an HLS-style caller and the prewrapped DUFT
//   core register port. One accepted ap_start moves LEN+1 read or write beats
//   to consecutive core addresses (base+i, wrapping modulo 2^ADDR_W). A new
//   command may be accepted straight from DONE, so chained bursts see no
//   IDLE bubble. A beat landing on IDLE_ADDR is not sent to the core, still
//   counts as a beat, reads back 0 and sets the sticky err flag.
//
//   Ports:
//     clk        clock
//     ap_rst_n   asynchronous active-low reset
//     bus        duft_ap_chain_burst_if.slave (command, status, beats, core)
//
//   Optional build macro:
//     DUFT_RD_CHECKSUM_EN  read-burst ap_return is the XOR of all beat data
//                          instead of the last beat.
// ---------------------------------------------------------------------------
module duft_ap_chain_burst #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                LEN_W     = 4,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '1
) (
    input logic                   clk,
    input logic                   ap_rst_n,
    duft_ap_chain_burst_if.slave  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_BEAT   = 3'd1;
    localparam logic [2:0] S_WR_BEAT   = 3'd2;
    localparam logic [2:0] S_WR_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  cnt_max_q, cnt_max_d;
    logic [LEN_W-1:0]  i_q, i_d;
    logic [DATA_W-1:0] ap_return_q, ap_return_d;
    logic [DATA_W-1:0] rd_beat_data_q, rd_beat_data_d;
    logic              rd_beat_valid_q, rd_beat_valid_d;
    logic              ap_ready_q, ap_ready_d;
    logic              err_q, err_d;
`ifdef DUFT_RD_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic [ADDR_W-1:0] beat_addr;
    logic              beat_sup;
    logic [DATA_W-1:0] rd_beat_in;
    logic              last_beat;
    logic              accept;

    assign beat_addr  = base_q + ADDR_W'(i_q);
    assign beat_sup   = (beat_addr == IDLE_ADDR);
    assign rd_beat_in = beat_sup ? '0 : bus.core_rd_msg;
    assign last_beat  = (i_q == cnt_max_q);
    // A command is taken from IDLE, or from DONE once ap_done is acknowledged.
    assign accept     = bus.ap_start &&
                        ((state_q == S_IDLE) ||
                         ((state_q == S_DONE) && bus.ap_continue));

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        cnt_max_d       = cnt_max_q;
        i_d             = i_q;
        ap_return_d     = ap_return_q;
        rd_beat_data_d  = rd_beat_data_q;
        rd_beat_valid_d = 1'b0;
        ap_ready_d      = 1'b0;
        err_d           = err_q;
`ifdef DUFT_RD_CHECKSUM_EN
        csum_d          = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
            end
            S_RD_BEAT: begin
                rd_beat_data_d  = rd_beat_in;
                rd_beat_valid_d = 1'b1;
`ifdef DUFT_RD_CHECKSUM_EN
                csum_d          = csum_q ^ rd_beat_in;
`endif
                if (beat_sup) err_d = 1'b1;
                if (last_beat) begin
                    state_d    = S_DONE;
                    ap_ready_d = 1'b1;
`ifdef DUFT_RD_CHECKSUM_EN
                    ap_return_d = csum_q ^ rd_beat_in;
`else
                    ap_return_d = rd_beat_in;
`endif
                end else begin
                    i_d = i_q + LEN_W'(1);
                end
            end
            S_WR_BEAT: begin
                if (beat_sup) err_d = 1'b1;
                if (last_beat) state_d = S_WR_SETTLE;
                else           i_d     = i_q + LEN_W'(1);
            end
            S_WR_SETTLE: begin
                state_d     = S_DONE;
                ap_ready_d  = 1'b1;
                ap_return_d = DATA_W'(cnt_max_q) + DATA_W'(1);
            end
            S_DONE: begin
                if (bus.ap_continue && !bus.ap_start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Command acceptance is common to IDLE and DONE, so it is applied
        // last and overrides whatever the state branch chose.
        if (accept) begin
            state_d   = bus.rd_wr ? S_RD_BEAT : S_WR_BEAT;
            base_d    = bus.addr;
            cnt_max_d = bus.len;
            i_d       = '0;
            err_d     = 1'b0;
`ifdef DUFT_RD_CHECKSUM_EN
            csum_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            cnt_max_q       <= '0;
            i_q             <= '0;
            ap_return_q     <= '0;
            rd_beat_data_q  <= '0;
            rd_beat_valid_q <= 1'b0;
            ap_ready_q      <= 1'b0;
            err_q           <= 1'b0;
`ifdef DUFT_RD_CHECKSUM_EN
            csum_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            cnt_max_q       <= cnt_max_d;
            i_q             <= i_d;
            ap_return_q     <= ap_return_d;
            rd_beat_data_q  <= rd_beat_data_d;
            rd_beat_valid_q <= rd_beat_valid_d;
            ap_ready_q      <= ap_ready_d;
            err_q           <= err_d;
`ifdef DUFT_RD_CHECKSUM_EN
            csum_q          <= csum_d;
`endif
        end
    end

    // Core addresses decode from state only, so reset parks them at
    // IDLE_ADDR immediately and the two ports can never be active together.
    assign bus.core_rd_addr  = ((state_q == S_RD_BEAT) && !beat_sup) ? beat_addr : IDLE_ADDR;
    assign bus.core_wr_addr  = ((state_q == S_WR_BEAT) && !beat_sup) ? beat_addr : IDLE_ADDR;
    assign bus.core_wr_msg   = bus.wr_data;
    assign bus.wr_data_ack   = (state_q == S_WR_BEAT);
    assign bus.rd_beat_data  = rd_beat_data_q;
    assign bus.rd_beat_valid = rd_beat_valid_q;
    assign bus.ap_idle       = (state_q == S_IDLE) && !bus.ap_start;
    assign bus.ap_done       = (state_q == S_DONE);
    assign bus.ap_ready      = ap_ready_q;
    assign bus.ap_return     = ap_return_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_duft_ap_chain_burst.sv
// ---------------------------------------------------------------------------
// tb_duft_ap_chain_burst
//   Self-checking bench for duft_ap_chain_burst. A 64-word aliasing core
//   (indexed by address[5:0], unwritten words read as index*2) sits on the
//   core port; a command-level reference memory predicts every beat, the
//   burst result, err and the per-cycle handshake.
// ---------------------------------------------------------------------------
module tb_duft_ap_chain_burst;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic ap_rst_n;
    always #5 clk = ~clk;

    duft_ap_chain_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    duft_ap_chain_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .IDLE_ADDR(ONES)
    ) dut (
        .clk(clk), .ap_rst_n(ap_rst_n), .bus(bus)
    );

    // Core: combinational read, 1-cycle committed write.
    logic [31:0] core_mem [64];
    bit          written  [64];
    logic [5:0]  rd_ix;
    assign rd_ix           = bus.core_rd_addr[5:0];
    assign bus.core_rd_msg = written[rd_ix] ? core_mem[rd_ix] : {25'd0, rd_ix, 1'b0};
    always @(posedge clk) begin
        if (bus.core_wr_addr != ONES) begin
            core_mem[bus.core_wr_addr[5:0]] <= bus.core_wr_msg;
            written[bus.core_wr_addr[5:0]]  <= 1'b1;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] wdat    [16];
    logic [31:0] exp_ret;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst from IDLE or DONE and ends in the first DONE cycle.
    task automatic do_burst(input bit rd, input logic [31:0] a, input logic [3:0] l);
        logic [31:0] ba, bd, prev, acc, exp_rd, exp_wr;
        bit sup, exp_err;
        int unsigned n;
        n = int'(l) + 1;
        bus.ap_start = 1'b1; bus.rd_wr = rd; bus.addr = a; bus.len = l; bus.ap_continue = 1'b1;
        tick();
        bus.ap_start = 1'b0; bus.ap_continue = 1'b0;
        bus.addr = $urandom; bus.len = 4'($urandom); bus.rd_wr = ~rd;
        prev = '0; acc = '0; exp_err = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            ba  = a + k;
            sup = (ba == ONES);
            exp_rd = (rd && !sup) ? ba : ONES;
            exp_wr = (!rd && !sup) ? ba : ONES;
            if (!rd) bus.wr_data = wdat[k];
            #1;
            checks++;
            if ({bus.ap_done, bus.ap_idle, bus.ap_ready} !== 3'b000) begin
                errors++; $display("FAIL beat_status k=%0d got=%b exp=000", k, {bus.ap_done, bus.ap_idle, bus.ap_ready});
            end
            checks++;
            if (bus.core_rd_addr !== exp_rd) begin
                errors++; $display("FAIL core_rd_addr k=%0d got=%h exp=%h", k, bus.core_rd_addr, exp_rd);
            end
            checks++;
            if (bus.core_wr_addr !== exp_wr) begin
                errors++; $display("FAIL core_wr_addr k=%0d got=%h exp=%h", k, bus.core_wr_addr, exp_wr);
            end
            checks++;
            if (bus.wr_data_ack !== !rd) begin
                errors++; $display("FAIL wr_data_ack k=%0d got=%b exp=%b", k, bus.wr_data_ack, !rd);
            end
            if (!rd) begin
                checks++;
                if (bus.core_wr_msg !== wdat[k]) begin
                    errors++; $display("FAIL core_wr_msg k=%0d got=%h exp=%h", k, bus.core_wr_msg, wdat[k]);
                end
            end
            checks++;
            if (bus.rd_beat_valid !== (rd && k > 0)) begin
                errors++; $display("FAIL rd_beat_valid k=%0d got=%b exp=%b", k, bus.rd_beat_valid, (rd && k > 0));
            end
            if (rd && k > 0) begin
                checks++;
                if (bus.rd_beat_data !== prev) begin
                    errors++; $display("FAIL rd_beat_data k=%0d got=%h exp=%h", k, bus.rd_beat_data, prev);
                end
            end
            if (k == 0) begin
                checks++;
                if (bus.err !== 1'b0) begin
                    errors++; $display("FAIL err_clear got=%b exp=0", bus.err);
                end
            end
            if (rd) begin
                bd = sup ? 32'd0 : ref_mem[ba[5:0]];
                prev = bd;
                acc  = acc ^ bd;
            end else if (!sup) begin
                ref_mem[ba[5:0]] = wdat[k];
            end
            if (sup) exp_err = 1'b1;
            tick();
        end
        if (!rd) begin
            #1;
            checks++;
            if ({bus.core_rd_addr, bus.core_wr_addr} !== {ONES, ONES} || bus.wr_data_ack !== 1'b0 || bus.ap_done !== 1'b0) begin
                errors++; $display("FAIL settle got rd=%h wr=%h ack=%b done=%b exp rd/wr=ones ack=0 done=0",
                                   bus.core_rd_addr, bus.core_wr_addr, bus.wr_data_ack, bus.ap_done);
            end
            tick();
        end
        #1;
`ifdef DUFT_RD_CHECKSUM_EN
        exp_ret = rd ? acc : (32'(l) + 32'd1);
`else
        exp_ret = rd ? prev : (32'(l) + 32'd1);
`endif
        checks++;
        if ({bus.ap_done, bus.ap_ready} !== 2'b11) begin
            errors++; $display("FAIL done_entry got done/ready=%b exp=11", {bus.ap_done, bus.ap_ready});
        end
        checks++;
        if ({bus.core_rd_addr, bus.core_wr_addr} !== {ONES, ONES}) begin
            errors++; $display("FAIL done_addr got rd=%h wr=%h exp=ones", bus.core_rd_addr, bus.core_wr_addr);
        end
        checks++;
        if (bus.ap_return !== exp_ret) begin
            errors++; $display("FAIL ap_return got=%h exp=%h", bus.ap_return, exp_ret);
        end
        checks++;
        if (bus.err !== exp_err) begin
            errors++; $display("FAIL err got=%b exp=%b", bus.err, exp_err);
        end
        checks++;
        if (bus.rd_beat_valid !== rd) begin
            errors++; $display("FAIL last_valid got=%b exp=%b", bus.rd_beat_valid, rd);
        end
        if (rd) begin
            checks++;
            if (bus.rd_beat_data !== prev) begin
                errors++; $display("FAIL last_beat_data got=%h exp=%h", bus.rd_beat_data, prev);
            end
        end
    endtask

    // Stays in DONE without ap_continue for 'hold' more cycles.
    task automatic hold_done(input bit hold_start, input int unsigned hold);
        for (int unsigned h = 0; h < hold; h++) begin
            bus.ap_start = hold_start; bus.ap_continue = 1'b0;
            bus.addr = $urandom; bus.rd_wr = 1'($urandom);
            tick(); #1;
            checks++;
            if ({bus.ap_done, bus.ap_ready, bus.ap_idle, bus.rd_beat_valid, bus.wr_data_ack} !== 5'b10000) begin
                errors++; $display("FAIL hold_status h=%0d got=%b exp=10000", h,
                                   {bus.ap_done, bus.ap_ready, bus.ap_idle, bus.rd_beat_valid, bus.wr_data_ack});
            end
            checks++;
            if ({bus.core_rd_addr, bus.core_wr_addr} !== {ONES, ONES}) begin
                errors++; $display("FAIL hold_addr h=%0d got rd=%h wr=%h exp=ones", h, bus.core_rd_addr, bus.core_wr_addr);
            end
            checks++;
            if (bus.ap_return !== exp_ret) begin
                errors++; $display("FAIL hold_return got=%h exp=%h", bus.ap_return, exp_ret);
            end
        end
    endtask

    task automatic do_release();
        bus.ap_start = 1'b0; bus.ap_continue = 1'b1;
        tick(); #1;
        bus.ap_continue = 1'b0;
        checks++;
        if ({bus.ap_idle, bus.ap_done} !== 2'b10) begin
            errors++; $display("FAIL release got idle/done=%b exp=10", {bus.ap_idle, bus.ap_done});
        end
        checks++;
        if (bus.ap_return !== exp_ret) begin
            errors++; $display("FAIL return_hold got=%h exp=%h", bus.ap_return, exp_ret);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        bus.ap_start = 1'b0; bus.rd_wr = 1'b0; bus.addr = '0; bus.len = '0;
        bus.wr_data = '0; bus.ap_continue = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'd2;
        exp_ret = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.core_rd_addr, bus.core_wr_addr} !== {ONES, ONES}) begin
            errors++; $display("FAIL reset_addr got rd=%h wr=%h exp=ones", bus.core_rd_addr, bus.core_wr_addr);
        end
        checks++;
        if ({bus.ap_idle, bus.ap_done, bus.ap_ready, bus.rd_beat_valid, bus.wr_data_ack, bus.err} !== 6'b100000) begin
            errors++; $display("FAIL reset_status got=%b exp=100000",
                               {bus.ap_idle, bus.ap_done, bus.ap_ready, bus.rd_beat_valid, bus.wr_data_ack, bus.err});
        end
        checks++;
        if ({bus.ap_return, bus.rd_beat_data} !== 64'd0) begin
            errors++; $display("FAIL reset_data got ret=%h beat=%h exp=0", bus.ap_return, bus.rd_beat_data);
        end
        ap_rst_n = 1'b1;
        tick(); #1;
        checks++;
        if (bus.ap_idle !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset got=%b exp=1", bus.ap_idle);
        end
    endtask

    task automatic test_read_burst();
        do_burst(1'b1, 32'h10, 4'd3);
        checks++;
`ifdef DUFT_RD_CHECKSUM_EN
        if (bus.ap_return !== 32'h0) begin
            errors++; $display("FAIL read_ex_return got=%h exp=%h", bus.ap_return, 32'h0);
        end
`else
        if (bus.ap_return !== 32'h26) begin
            errors++; $display("FAIL read_ex_return got=%h exp=%h", bus.ap_return, 32'h26);
        end
`endif
        hold_done(1'b0, 1);
        do_release();
    endtask

    task automatic test_write_burst();
        wdat[0] = 32'hA; wdat[1] = 32'hB;
        do_burst(1'b0, 32'h20, 4'd1);
        checks++;
        if (bus.ap_return !== 32'd2) begin
            errors++; $display("FAIL write_ex_return got=%h exp=2", bus.ap_return);
        end
        do_release();
    endtask

    task automatic test_back_to_back();
        do_burst(1'b1, 32'h20, 4'd1);
        hold_done(1'b1, 5);
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        do_burst(1'b0, 32'h08, 4'd2);
        do_burst(1'b1, 32'h07, 4'd4);
        do_release();
    endtask

    task automatic test_wrap_idle_addr();
        do_burst(1'b1, 32'hFFFF_FFFE, 4'd2);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL wrap_err got=%b exp=1", bus.err);
        end
        do_release();
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        do_burst(1'b0, 32'hFFFF_FFFC, 4'd5);
        do_release();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] a;
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        bus.ap_start = 1'b1; bus.rd_wr = 1'b0; bus.addr = 32'h40; bus.len = 4'd7;
        tick();
        bus.ap_start = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            a = 32'h40 + k;
            bus.wr_data = wdat[k];
            #1;
            checks++;
            if (bus.core_wr_addr !== a || bus.wr_data_ack !== 1'b1) begin
                errors++; $display("FAIL pre_reset_beat k=%0d got=%h/%b exp=%h/1", k, bus.core_wr_addr, bus.wr_data_ack, a);
            end
            ref_mem[a[5:0]] = wdat[k];
            tick();
        end
        bus.wr_data = wdat[3];
        #1;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.core_wr_addr !== ONES || bus.wr_data_ack !== 1'b0 || bus.core_rd_addr !== ONES) begin
            errors++; $display("FAIL async_reset got wr=%h ack=%b rd=%h exp=ones/0/ones",
                               bus.core_wr_addr, bus.wr_data_ack, bus.core_rd_addr);
        end
        tick(); tick();
        ap_rst_n = 1'b1;
        #1;
        exp_ret = '0;
        checks++;
        if ({bus.ap_idle, bus.ap_done, bus.err} !== 3'b100 || bus.ap_return !== 32'd0 || bus.rd_beat_data !== 32'd0) begin
            errors++; $display("FAIL after_reset got idle/done/err=%b ret=%h beat=%h exp=100 0 0",
                               {bus.ap_idle, bus.ap_done, bus.err}, bus.ap_return, bus.rd_beat_data);
        end
        tick();
        do_burst(1'b1, 32'h40, 4'd3);
        do_release();
    endtask

    task automatic test_checksum();
        wdat[0] = 32'h1; wdat[1] = 32'h2; wdat[2] = 32'h4;
        do_burst(1'b0, 32'h30, 4'd2);
        do_release();
        do_burst(1'b1, 32'h30, 4'd2);
        checks++;
`ifdef DUFT_RD_CHECKSUM_EN
        if (bus.ap_return !== 32'h7) begin
            errors++; $display("FAIL checksum_return got=%h exp=7", bus.ap_return);
        end
`else
        if (bus.ap_return !== 32'h4) begin
            errors++; $display("FAIL checksum_return got=%h exp=4", bus.ap_return);
        end
`endif
        do_release();
    endtask

    task automatic test_random();
        bit rd;
        logic [31:0] base;
        for (int t = 0; t < 16; t++) begin
            rd   = 1'($urandom);
            base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                               : 32'($urandom_range(0, 63));
            for (int i = 0; i < 16; i++) wdat[i] = $urandom;
            do_burst(rd, base, 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                hold_done(1'($urandom), $urandom_range(0, 2));
            end else begin
                hold_done(1'b0, $urandom_range(0, 1));
                do_release();
            end
        end
        do_release();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_read_burst();
        test_write_burst();
        test_back_to_back();
        test_wrap_idle_addr();
        test_reset_mid_burst();
        test_checksum();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/duft_ap_chain_burst.md
Name: duft_ap_chain_burst

Overview:
- Parametrised ap_ctrl_chain bridge between an HLS-style caller and the prewrapped DUFT core's register port.
- One ap_start moves a burst of LEN+1 read or write beats to consecutive core addresses.
- Supports chained back-to-back commands from DONE, with no IDLE bubble.
- Replaces the single-access wrapper. It sits between the HLS top and the prewrapped core.

Parameters:
- ADDR_W, 32, address width of command and core ports
- DATA_W, 32, data width of write data, read data and ap_return
- LEN_W, 4, burst length field width; burst = len+1 beats (1..2^LEN_W)
- IDLE_ADDR, all-ones, sentinel address driven to the core when no access is active

Ports:
- clk  in  1  clock
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- ap_start  in  1  command request (rd_wr, addr, len valid while high)
- rd_wr  in  1  1=read burst, 0=write burst
- addr  in  ADDR_W  burst base address
- len  in  LEN_W  beats minus one
- wr_data  in  DATA_W  write beat data; caller advances on wr_data_ack
- wr_data_ack  out  1  pulse: wr_data consumed this cycle
- rd_beat_data  out  DATA_W  registered read beat data
- rd_beat_valid  out  1  pulse: rd_beat_data holds a new beat
- ap_idle / ap_ready / ap_done  out  1  ap_ctrl_chain status
- ap_continue  in  1  caller acknowledges ap_done
- ap_return  out  DATA_W  burst result
- err  out  1  sticky: a beat hit IDLE_ADDR; cleared on next accepted command
- core_rd_addr / core_wr_addr  out  ADDR_W  core access addresses (IDLE_ADDR when inactive)
- core_wr_msg  out  DATA_W  equals wr_data
- core_rd_msg  in  DATA_W  core combinational read data

Behaviour:
- Reset (async, ap_rst_n=0): state=IDLE, beat counter=0, ap_return=0, rd_beat_data=0, err=0. All pulses low. Core addresses=IDLE_ADDR immediately. Reset mid-burst aborts the burst with no further core access.
- States:
  - IDLE: ap_start&rd_wr -> RD_BEAT; ap_start&!rd_wr -> WR_BEAT. On either, latch base=addr, cnt_max=len, i=0, clear err. ap_idle=!ap_start.
  - RD_BEAT: core_rd_addr=base+i (mod 2^ADDR_W). At the clock edge, capture core_rd_msg into rd_beat_data; rd_beat_valid=1 the following cycle. i==cnt_max -> DONE, else i++.
  - WR_BEAT: core_wr_addr=base+i; wr_data_ack=1 the same cycle. i==cnt_max -> WR_SETTLE, else i++.
  - WR_SETTLE: one cycle, no access, so the core's 1-cycle write commits before ap_done.
  - DONE: ap_done=1 until accepted.
    - ap_continue&!ap_start -> IDLE.
    - ap_continue&ap_start -> accept the new command directly (RD_BEAT/WR_BEAT); ap_done falls.
    - !ap_continue -> hold; ap_start is ignored.
- ap_ready: one-cycle pulse on the transition into DONE. This is the same cycle ap_done first rises.
- ap_return, written on entry to DONE:
  - read burst: last beat data
  - write burst: len+1, zero-extended
  - Holds until the next DONE entry.
- Latency: read burst = len+1 cycles to DONE; write burst = len+2 cycles.
- Address wrap: base+i wraps modulo 2^ADDR_W.
- IDLE_ADDR beat: a beat whose address equals IDLE_ADDR suppresses the core access. It still counts as a beat: for a read, captured data=0; for a write, wr_data_ack still pulses. err sets.
- addr/len/rd_wr changes after acceptance are ignored.
- Core addresses are never both non-IDLE in the same cycle.

Optional Feature:
- DUFT_RD_CHECKSUM_EN defined: a read burst's ap_return is the XOR of all beat data. Suppressed beats contribute 0.
- Undefined: ap_return is the last read beat. Write behaviour is identical either way.

Test Plan:
- Reset, then read burst addr=0x10, len=3, core returns addr*2 -> core_rd_addr 0x10..0x13 on 4 consecutive cycles; ap_ready/ap_done rise in cycle 4; ap_return=0x26; rd_beat_valid pulses 4 times.
- Write burst addr=0x20, len=1, wr_data 0xA then 0xB -> core_wr_addr 0x20, 0x21 with matching msgs; 2 wr_data_ack pulses; WR_SETTLE; ap_done with ap_return=2.
- Hold ap_continue=0 for 5 cycles in DONE with ap_start=1 -> no core access, ap_done stays 1. Then ap_continue=1 with ap_start=1 -> next burst starts the following cycle and ap_idle never rises.
- Read addr=0xFFFFFFFE, len=2 -> accesses 0xFFFFFFFE and 0x00000000; the 0xFFFFFFFF beat is suppressed; err=1; beat data 0.
- Deassert ap_rst_n mid write burst -> core_wr_addr=IDLE_ADDR asynchronously; after release, ap_idle=1 and ap_return=0.
- With DUFT_RD_CHECKSUM_EN, read of 3 beats 0x1, 0x2, 0x4 -> ap_return=0x7. Without it -> ap_return=0x4.
